// File: rtl/rx_tune_ctrl_pkg.sv
// ============================================================================
//  Module   : rx_tune_ctrl_pkg
//  Purpose  : Shared types and constants for the RX tuning controller.
//             State encoding for the commit/settle FSM and the width of the
//             saturating retune counter.
//  Options  : RX_TUNE_SWEEP_EN (see rx_tune_ctrl) does not affect this file.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_tune_ctrl_pkg;

    // Width of the saturating commit counter.
    localparam int unsigned RETUNE_CNT_W = 16;

    // Width of the settle count-down (SETTLE_CYC is limited to 1..255).
    localparam int unsigned SETTLE_CNT_W = 8;

    // Width of the optional sweep divider.
    localparam int unsigned SWEEP_DIV_W  = 16;

    // Commit/settle FSM encoding.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } tune_state_t;

endpackage : rx_tune_ctrl_pkg

`default_nettype wire

// File: rtl/rx_tune_ctrl_if.sv
// ============================================================================
//  Module   : rx_tune_ctrl_if
//  Purpose  : Host-bus and mixer-side signal bundle for rx_tune_ctrl.
//  Modports : master - host / mixer model (drives writes, sync, din_valid)
//             slave  - rx_tune_ctrl (drives phase_inc, dout_valid, busy,
//                      retune_cnt)
//  Signals  : wr_en, wr_pinc[31:0], sync_mode, sync, din_valid  (to ctrl)
//             phase_inc[31:0], dout_valid, busy, retune_cnt[15:0] (from ctrl)
//             sweep_en, sweep_step[31:0], sweep_div[15:0] (to ctrl, only
//             when RX_TUNE_SWEEP_EN is defined)
//  Options  : RX_TUNE_SWEEP_EN adds the sweep control signals.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_tune_ctrl_if;
    import rx_tune_ctrl_pkg::*;

    logic                    wr_en;
    logic [31:0]             wr_pinc;
    logic                    sync_mode;
    logic                    sync;
    logic [31:0]             phase_inc;
    logic                    din_valid;
    logic                    dout_valid;
    logic                    busy;
    logic [RETUNE_CNT_W-1:0] retune_cnt;
`ifdef RX_TUNE_SWEEP_EN
    logic                    sweep_en;
    logic [31:0]             sweep_step;
    logic [SWEEP_DIV_W-1:0]  sweep_div;
`endif

    modport master (
        output wr_en, wr_pinc, sync_mode, sync, din_valid,
`ifdef RX_TUNE_SWEEP_EN
        output sweep_en, sweep_step, sweep_div,
`endif
        input  phase_inc, dout_valid, busy, retune_cnt
    );

    modport slave (
        input  wr_en, wr_pinc, sync_mode, sync, din_valid,
`ifdef RX_TUNE_SWEEP_EN
        input  sweep_en, sweep_step, sweep_div,
`endif
        output phase_inc, dout_valid, busy, retune_cnt
    );

endinterface : rx_tune_ctrl_if

`default_nettype wire

// File: rtl/rx_tune_settle_timer.sv
// ============================================================================
//  Module   : rx_tune_settle_timer
//  Purpose  : Loadable count-down timer. Used for the post-commit settle
//             window and, when sweeping is built in, for the sweep divider.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             load         - load load_val (priority over counting)
//             load_val     - value to load
//             en           - decrement enable (holds at zero)
//             done         - count has reached zero
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_tune_settle_timer #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              load,
    input  wire  [WIDTH-1:0] load_val,
    input  wire              en,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule : rx_tune_settle_timer

`default_nettype wire

// File: rtl/rx_tune_ctrl.sv
// ============================================================================
//  Module   : rx_tune_ctrl
//  Purpose  : Tuning controller for one RX IQ mixer/DDS channel. Holds a
//             host-written shadow phase increment and commits it to the
//             mixer either on the next cycle or on a frame sync strobe, then
//             blanks the sample-valid stream for SETTLE_CYC cycles so that
//             downstream stages never see transient mixed samples.
//  Params   : SETTLE_CYC - blanking cycles after a commit (1..255)
//             RESET_PINC - phase_inc value from reset
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             bus        - rx_tune_ctrl_if.slave
//                          in : wr_en, wr_pinc, sync_mode, sync, din_valid
//                          out: phase_inc, dout_valid, busy, retune_cnt
//  Options  : RX_TUNE_SWEEP_EN - adds sweep_en/sweep_step/sweep_div and a
//             linear phase-increment sweep while idle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_tune_ctrl
    import rx_tune_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 6,
    parameter logic [31:0] RESET_PINC = 32'h0
) (
    input wire            clk,
    input wire            rst,
    rx_tune_ctrl_if.slave bus
);

    localparam logic [SETTLE_CNT_W-1:0] c_SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);
    localparam logic [RETUNE_CNT_W-1:0] c_RETUNE_MAX  = '1;

    tune_state_t             r_state;
    logic [31:0]             r_shadow;
    logic [31:0]             r_phase_inc;
    logic                    r_pending;
    logic [RETUNE_CNT_W-1:0] r_retune_cnt;

    logic                    w_pending_eff;
    logic                    w_go;
    logic                    w_settle_done;

    // A write in the same cycle counts as pending, so a write coincident
    // with sync (or any write in immediate mode) commits on this edge.
    assign w_pending_eff = r_pending | bus.wr_en;
    assign w_go          = w_pending_eff & (bus.sync_mode ? bus.sync : 1'b1);

    // Settle window: loaded on every commit, so a commit during SETTLE
    // restarts the full blanking period.
    rx_tune_settle_timer #(
        .WIDTH   (SETTLE_CNT_W),
        .RST_VAL (c_SETTLE_LOAD)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (w_go),
        .load_val (c_SETTLE_LOAD),
        .en       (r_state == ST_SETTLE),
        .done     (w_settle_done)
    );

`ifdef RX_TUNE_SWEEP_EN
    logic w_sweep_step;
    logic w_div_load;
    logic w_div_done;

    // The divider is held at sweep_div whenever sweeping is not running
    // (disabled, settling, or a commit this cycle), and reloaded after each
    // step, so each step is sweep_div+1 idle cycles after the previous one.
    assign w_sweep_step = bus.sweep_en & (r_state == ST_IDLE) & w_div_done & ~w_go;
    assign w_div_load   = ~bus.sweep_en | w_go | (r_state != ST_IDLE) | w_sweep_step;

    rx_tune_settle_timer #(
        .WIDTH   (SWEEP_DIV_W),
        .RST_VAL ('0)
    ) u_sweep_div (
        .clk      (clk),
        .rst      (rst),
        .load     (w_div_load),
        .load_val (bus.sweep_div),
        .en       (1'b1),
        .done     (w_div_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SETTLE;
            r_shadow     <= RESET_PINC;
            r_phase_inc  <= RESET_PINC;
            r_pending    <= 1'b0;
            r_retune_cnt <= '0;
        end else begin
            if (bus.wr_en) begin
                r_shadow <= bus.wr_pinc;
            end

            if (w_go) begin
                // Forward a same-cycle write so it is not lost behind the
                // shadow register update.
                r_phase_inc <= bus.wr_en ? bus.wr_pinc : r_shadow;
                r_pending   <= 1'b0;
                r_state     <= ST_SETTLE;
                if (r_retune_cnt != c_RETUNE_MAX) begin
                    r_retune_cnt <= r_retune_cnt + RETUNE_CNT_W'(1);
                end
            end else begin
                if (bus.wr_en) begin
                    r_pending <= 1'b1;
                end
                if ((r_state == ST_SETTLE) && w_settle_done) begin
                    r_state <= ST_IDLE;
                end
`ifdef RX_TUNE_SWEEP_EN
                if (w_sweep_step) begin
                    r_phase_inc <= r_phase_inc + bus.sweep_step;
                end
`endif
            end
        end
    end

    assign bus.phase_inc  = r_phase_inc;
    assign bus.retune_cnt = r_retune_cnt;
    assign bus.busy       = r_pending | (r_state == ST_SETTLE);
    assign bus.dout_valid = bus.din_valid & (r_state == ST_IDLE);

endmodule : rx_tune_ctrl

`default_nettype wire

// File: tb/tb_rx_tune_ctrl.sv
// ============================================================================
//  Module   : tb_rx_tune_ctrl
//  Purpose  : Directed self-checking bench for rx_tune_ctrl (SETTLE_CYC=6,
//             RESET_PINC=0). Sweep checks are included when
//             RX_TUNE_SWEEP_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_tune_ctrl;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    rx_tune_ctrl_if bus ();

    rx_tune_ctrl #(
        .SETTLE_CYC (6),
        .RESET_PINC (32'h0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total        = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_pinc    = 32'h0;
        bus.sync_mode  = 1'b0;
        bus.sync       = 1'b0;
        bus.din_valid  = 1'b1;
`ifdef RX_TUNE_SWEEP_EN
        bus.sweep_en   = 1'b0;
        bus.sweep_step = 32'h0;
        bus.sweep_div  = 16'h0;
`endif

        // ---------------- reset and post-reset settle
        tick();
        tick();
        check("rst_pinc", bus.phase_inc, 32'h0);
        check("rst_dv", {31'b0, bus.dout_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd1);
        check("rst_cnt", {16'b0, bus.retune_cnt}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rst_blank", {31'b0, bus.dout_valid}, 32'd0);
            tick();
        end
        check("rst_dv_up", {31'b0, bus.dout_valid}, 32'd1);
        check("rst_busy_dn", {31'b0, bus.busy}, 32'd0);

        // ---------------- immediate commit
        bus.sync_mode = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_pinc   = 32'h0123_4567;
        tick();
        bus.wr_en = 1'b0;
        check("imm_pinc", bus.phase_inc, 32'h0123_4567);
        check("imm_cnt", {16'b0, bus.retune_cnt}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("imm_blank", {31'b0, bus.dout_valid}, 32'd0);
            check("imm_busy", {31'b0, bus.busy}, 32'd1);
            tick();
        end
        check("imm_dv_up", {31'b0, bus.dout_valid}, 32'd1);
        check("imm_busy_dn", {31'b0, bus.busy}, 32'd0);

        // ---------------- sync commit with overwrite
        bus.sync_mode = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_pinc   = 32'h1000;
        tick();
        bus.wr_pinc   = 32'h2000;
        tick();
        bus.wr_en = 1'b0;
        check("sync_hold_pinc", bus.phase_inc, 32'h0123_4567);
        check("sync_pend_busy", {31'b0, bus.busy}, 32'd1);
        check("sync_hold_dv", {31'b0, bus.dout_valid}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("sync_wait_pinc", bus.phase_inc, 32'h0123_4567);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        check("sync_pinc", bus.phase_inc, 32'h2000);
        check("sync_cnt", {16'b0, bus.retune_cnt}, 32'd2);
        check("sync_blank", {31'b0, bus.dout_valid}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("sync_dv_up", {31'b0, bus.dout_valid}, 32'd1);
        check("sync_busy_dn", {31'b0, bus.busy}, 32'd0);
        check("sync_cnt_once", {16'b0, bus.retune_cnt}, 32'd2);

        // sync with nothing pending does nothing
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        check("idle_sync_pinc", bus.phase_inc, 32'h2000);
        check("idle_sync_cnt", {16'b0, bus.retune_cnt}, 32'd2);
        check("idle_sync_dv", {31'b0, bus.dout_valid}, 32'd1);

        // ---------------- retune restart: 3 + 6 blanked cycles
        bus.sync_mode = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_pinc   = 32'h3000;
        tick();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_a_blank", {31'b0, bus.dout_valid}, 32'd0);
            if (i == 2) begin
                bus.wr_en   = 1'b1;
                bus.wr_pinc = 32'h4000;
            end
            tick();
        end
        bus.wr_en = 1'b0;
        check("restart_pinc", bus.phase_inc, 32'h4000);
        check("restart_cnt", {16'b0, bus.retune_cnt}, 32'd4);
        for (int i = 0; i < 6; i++) begin
            check("restart_blank", {31'b0, bus.dout_valid}, 32'd0);
            tick();
        end
        check("restart_dv_up", {31'b0, bus.dout_valid}, 32'd1);

        // ---------------- same-cycle write and sync
        bus.sync_mode = 1'b1;
        bus.wr_en     = 1'b1;
        bus.sync      = 1'b1;
        bus.wr_pinc   = 32'hDEAD_BEEF;
        tick();
        bus.wr_en = 1'b0;
        bus.sync  = 1'b0;
        check("fwd_pinc", bus.phase_inc, 32'hDEAD_BEEF);
        check("fwd_cnt", {16'b0, bus.retune_cnt}, 32'd5);
        for (int i = 0; i < 6; i++) tick();
        check("fwd_busy_dn", {31'b0, bus.busy}, 32'd0);

        // ---------------- reset with a write pending
        bus.wr_en   = 1'b1;
        bus.wr_pinc = 32'h5555;
        tick();
        bus.wr_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rrst_pinc", bus.phase_inc, 32'h0);
        check("rrst_cnt", {16'b0, bus.retune_cnt}, 32'd0);
        check("rrst_dv", {31'b0, bus.dout_valid}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("rrst_busy_dn", {31'b0, bus.busy}, 32'd0);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        check("rrst_no_commit", bus.phase_inc, 32'h0);

`ifdef RX_TUNE_SWEEP_EN
        // ---------------- sweep with wrap, then commit mid-sweep
        bus.sync_mode  = 1'b0;
        bus.sweep_step = 32'h10;
        bus.sweep_div  = 16'd3;
        bus.wr_en      = 1'b1;
        bus.wr_pinc    = 32'hFFFF_FFF8;
        tick();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("sw_start", bus.phase_inc, 32'hFFFF_FFF8);
        bus.sweep_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("sw_hold", bus.phase_inc, 32'hFFFF_FFF8);
        tick();
        check("sw_wrap", bus.phase_inc, 32'h0000_0008);
        check("sw_dv", {31'b0, bus.dout_valid}, 32'd1);
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_pinc = 32'h7000;
        tick();
        bus.wr_en = 1'b0;
        check("sw_commit", bus.phase_inc, 32'h7000);
        check("sw_commit_cnt", {16'b0, bus.retune_cnt}, 32'd2);
        for (int i = 0; i < 6; i++) tick();
        check("sw_settled_dv", {31'b0, bus.dout_valid}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("sw_resume_hold", bus.phase_inc, 32'h7000);
        tick();
        check("sw_resume_step", bus.phase_inc, 32'h7010);
        check("sw_step_cnt", {16'b0, bus.retune_cnt}, 32'd2);
        bus.sweep_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_rx_tune_ctrl

`default_nettype wire
